// File: rtl/data_memory_banked.sv
// Byte-lane data memory for an RV32 load/store port.
// One request per cycle, registered response one cycle after acceptance.
// An optional power-on clear sweep zeroes every word before requests are taken.
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses as errors. Left undefined, such accesses are forced to natural
// alignment instead.
`timescale 1ns/1ps
module data_memory_banked #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        init_done
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t         state_q;
  logic [AW-1:0]  clr_cnt_q;
  logic           ready_q, done_q;
  logic           rsp_valid_q, rsp_error_q;
  logic [31:0]    rsp_rdata_q;

  // Byte lanes kept as separate arrays, each with a single write port
  logic [7:0]     mem_q [4][DEPTH_WORDS];

  logic [AW-1:0]  widx;
  logic [1:0]     size, off;
  logic           illegal, misalign, err, fire;
  logic [3:0]     be;
  logic [31:0]    wdata_sh, rword, rsh, load_data;
  logic [3:0]     mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [31:0]    mem_wdata;
  logic           unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign widx        = req_addr[AW+1:2];
  assign size        = req_funct3[1:0];
  assign fire        = req_valid & ready_q;

  // Decode legality, alignment and byte enables for the current request
  always_comb begin
    illegal  = req_write ? (req_funct3[2] | (size == 2'd3))
                         : ((size == 2'd3) | (req_funct3 == 3'b110));
    misalign = ((size == 2'd1) & req_addr[0]) |
               ((size == 2'd2) & (req_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    off = req_addr[1:0];
    err = illegal | misalign;
`else
    if (size == 2'd1)      off = {req_addr[1], 1'b0};
    else if (size == 2'd2) off = 2'b00;
    else                   off = req_addr[1:0];
    err = illegal;
`endif
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    wdata_sh = req_wdata << {off, 3'b000};
  end

  // Single write port per lane: clear sweep owns it in CLEAR, stores in RUN
  always_comb begin
    mem_we    = 4'b0000;
    mem_waddr = widx;
    mem_wdata = wdata_sh;
    if (state_q == ST_CLEAR) begin
      mem_we    = 4'b1111;
      mem_waddr = clr_cnt_q;
      mem_wdata = 32'd0;
    end else if (fire && req_write && !err) begin
      mem_we    = be;
    end
  end

  // Array write, no reset on contents so it maps onto RAM
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem_q[b][mem_waddr] <= mem_wdata[b*8 +: 8];
  end

  // Read the addressed word and extract/extend the requested field
  always_comb begin
    for (int b = 0; b < 4; b++) rword[b*8 +: 8] = mem_q[b][widx];
    rsh = rword >> {off, 3'b000};
    case (req_funct3)
      3'b000:  load_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  load_data = {{16{rsh[15]}}, rsh[15:0]};
      3'b010:  load_data = rword;
      3'b100:  load_data = {24'd0, rsh[7:0]};
      3'b101:  load_data = {16'd0, rsh[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  // Control FSM: clear sweep then run; ready/done registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  // Response register, one cycle after acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= fire;
      rsp_error_q <= fire & err;
      rsp_rdata_q <= (fire && !req_write && !err) ? load_data : 32'd0;
    end
  end

  assign req_ready = ready_q;
  assign init_done = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
endmodule

// File: tb/tb_data_memory_banked.sv
// Scoreboard bench for data_memory_banked: stimulus pushes expected
// responses, a negedge monitor pops and compares on every rsp_valid.
`timescale 1ns/1ps
module tb_data_memory_banked;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        init_done;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  data_memory_banked #(.DEPTH_WORDS(1024), .INIT_CLEAR(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .init_done(init_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got data=%h err=%b want none", rsp_rdata, rsp_error);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, e[32]});
      end
    end
  end

  task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e);
    int t = 0;
    while (!req_ready && t < 2000) begin @(posedge clock); #1; t++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got ready=0 want 1");
    end
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    exp_q.push_back({exp_e, exp_d});
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  // Count edges from reset release until init_done rises
  task automatic sweep(input string name);
    int cyc = 0;
    bit ready_seen = 1'b0;
    while (!init_done && cyc < 3000) begin
      @(posedge clock); #1; cyc++;
      if (!init_done && req_ready) ready_seen = 1'b1;
    end
    chk({name, "_cycles"}, cyc, 1024);
    chk({name, "_ready_early"}, {31'd0, ready_seen}, 32'd0);
    chk({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drain();
    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ready",     {31'd0, req_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    reset = 1'b0;
    sweep("init");

    issue(0, 3'b010, 32'h3FC, 0, 32'h0, 0);                 // cleared word
    issue(1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0);       // SW
    issue(1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0);       // SB lane 1
    issue(0, 3'b010, 32'h10, 0, 32'h1122AA44, 0);
    issue(0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 0);           // LB
    issue(0, 3'b100, 32'h11, 0, 32'h000000AA, 0);           // LBU
    issue(0, 3'b001, 32'h12, 0, 32'h00001122, 0);           // LH
    issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 0);       // back-to-back
    issue(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0);
    issue(1, 3'b010, 32'h1004, 32'h5, 32'h0, 0);            // wraps to 0x4
    issue(0, 3'b010, 32'h4, 0, 32'h00000005, 0);
    issue(1, 3'b001, 32'h32, 32'h00008001, 32'h0, 0);       // SH upper half
    issue(0, 3'b010, 32'h30, 0, 32'h80010000, 0);
    issue(0, 3'b001, 32'h32, 0, 32'hFFFF8001, 0);
    issue(0, 3'b101, 32'h32, 0, 32'h00008001, 0);           // LHU
    issue(1, 3'b011, 32'h30, 32'h12345678, 32'h0, 1);       // illegal store
    issue(0, 3'b010, 32'h30, 0, 32'h80010000, 0);           // unchanged
    issue(0, 3'b011, 32'h30, 0, 32'h0, 1);                  // illegal load
    issue(0, 3'b110, 32'h30, 0, 32'h0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(0, 3'b010, 32'h22, 0, 32'h0, 1);
    issue(1, 3'b001, 32'h33, 32'hFFFF, 32'h0, 1);           // no write
    issue(0, 3'b010, 32'h30, 0, 32'h80010000, 0);
`else
    issue(0, 3'b010, 32'h22, 0, 32'hDEADBEEF, 0);
    issue(0, 3'b001, 32'h23, 0, 32'hFFFFDEAD, 0);           // forced to 0x22
    issue(0, 3'b010, 32'h33, 0, 32'h80010000, 0);
`endif
    drain();

    // Reset with a response in flight, then again mid-sweep
    issue(1, 3'b010, 32'h3FC, 32'h77, 32'h0, 0);
    issue(0, 3'b010, 32'h3FC, 0, 32'h77, 0);
    reset = 1'b1;
    #1;
    chk("inflight_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("inflight_rsp_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (500) @(posedge clock);
    #1;
    chk("mid_clear_done_pre", {31'd0, init_done}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_clear_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_clear_init_done", {31'd0, init_done}, 32'd0);
    chk("mid_clear_ready",     {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    sweep("resweep");
    issue(0, 3'b010, 32'h3FC, 0, 32'h0, 0);                 // 0x77 cleared
    issue(0, 3'b010, 32'h10, 0, 32'h0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
